// File: rtl/batch_accumulator_if.sv
// ---------------------------------------------------------------------------
// batch_accumulator_if
// Bundle of the job-request, beat-stream and result signals between the
// controller side (master) and the batch accumulator (slave).
//
//   start     master->slave  job request, only honoured while the engine idles
//   len       master->slave  number of beats in the requested job
//   in_valid  master->slave  upstream beat valid
//   in_data   master->slave  beat payload, unsigned
//   in_ready  slave->master  engine accepts a beat this cycle
//   all       slave->master  one-cycle job-complete pulse
//   run       slave->master  engine is consuming beats
//   sum       slave->master  accumulated result, held after the job
//   count     slave->master  beats accepted in the current/last job
//   overflow  slave->master  sticky carry-out flag for the current/last job
// ---------------------------------------------------------------------------
interface batch_accumulator_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int LEN_W  = 8
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              all;
    logic              run;
    logic [ACC_W-1:0]  sum;
    logic [LEN_W-1:0]  count;
    logic              overflow;

    // Controller / stimulus side
    modport master (
        output start, len, in_valid, in_data,
        input  in_ready, all, run, sum, count, overflow
    );

    // Accumulator side
    modport slave (
        input  start, len, in_valid, in_data,
        output in_ready, all, run, sum, count, overflow
    );
endinterface

// File: rtl/batch_accumulator.sv
// ---------------------------------------------------------------------------
// batch_accumulator
// Work engine that sums a fixed-length stream of unsigned beats. A job is
// requested with start/len while idle, beats are consumed while in RUN, and
// a one-cycle 'all' pulse marks completion. Sum, count and overflow stay
// held for readout until the next accepted start.
//
// Ports:
//   clk   rising-edge clock for all logic
//   rst   synchronous, active-high reset
//   bus   batch_accumulator_if.slave (start, len, in_valid, in_data in;
//         in_ready, all, run, sum, count, overflow out)
//
// Configuration macro:
//   BATCH_ACC_SATURATE_EN  defined   -> sum clamps to all-ones on overflow
//                          undefined -> sum wraps modulo 2^ACC_W
//   overflow is flagged in both builds.
// ---------------------------------------------------------------------------
module batch_accumulator #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int LEN_W  = 8
) (
    input logic                clk,
    input logic                rst,
    batch_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ACC_W-1:0]  sum_q, sum_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;

    logic              accept;
    logic              lastBeat;
    logic [ACC_W:0]    addFull;

    // A beat moves only while RUN advertises in_ready, so accept never
    // fires in IDLE or DONE and count can never pass len_q.
    assign accept   = bus.in_valid && (state_q == RUN);
    assign lastBeat = (count_q == len_q - 1'b1);

    // One extra bit on the adder exposes the carry out of the ACC_W-bit sum.
    assign addFull = {1'b0, sum_q} + {{(ACC_W - DATA_W + 1){1'b0}}, bus.in_data};

    // State register: reset forces IDLE regardless of where the job was,
    // which also abandons a running job without an 'all' pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a zero-length job skips RUN and completes straight
    // away; DONE always returns to IDLE so a start seen there is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = (bus.len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept && lastBeat) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded purely from the registered state.
    always_comb begin
        bus.in_ready = 1'b0;
        bus.run      = 1'b0;
        bus.all      = 1'b0;
        case (state_q)
            RUN: begin
                bus.in_ready = 1'b1;
                bus.run      = 1'b1;
            end
            DONE:    bus.all = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: a new job clears the results and latches len so
    // later changes on the len input are ignored; each accepted beat adds to
    // the sum and sets the sticky overflow flag on carry out.
    always_comb begin
        len_d      = len_q;
        sum_d      = sum_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (state_q == IDLE && bus.start) begin
            len_d      = bus.len;
            sum_d      = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (accept) begin
            count_d = count_q + 1'b1;
`ifdef BATCH_ACC_SATURATE_EN
            // Clamped sum stays at all-ones: any nonzero add carries again.
            sum_d = addFull[ACC_W] ? {ACC_W{1'b1}} : addFull[ACC_W-1:0];
`else
            sum_d = addFull[ACC_W-1:0];
`endif
            if (addFull[ACC_W]) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Datapath registers, cleared by reset so an aborted job leaves no
    // partial result behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            sum_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            len_q      <= len_d;
            sum_q      <= sum_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.sum      = sum_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_batch_accumulator.sv
// ---------------------------------------------------------------------------
// tb_batch_accumulator
// Directed bench for batch_accumulator. A default-width instance covers
// reset, normal, stalled, zero-length, large and aborted jobs; a 9-bit
// accumulator instance covers carry out of the accumulator, with the
// expected sum chosen by BATCH_ACC_SATURATE_EN.
// ---------------------------------------------------------------------------
module tb_batch_accumulator;

    logic clk;
    logic rst;

    int compareCount;
    int failCount;

    batch_accumulator_if #(.DATA_W(8), .ACC_W(16), .LEN_W(8)) bus  ();
    batch_accumulator_if #(.DATA_W(8), .ACC_W(9),  .LEN_W(8)) bus9 ();

    batch_accumulator #(.DATA_W(8), .ACC_W(16), .LEN_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    batch_accumulator #(.DATA_W(8), .ACC_W(9), .LEN_W(8)) dut9 (
        .clk (clk),
        .rst (rst),
        .bus (bus9.slave)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock; outputs are sampled and inputs driven 1 unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the default instance's request/stream inputs
    task automatic applyStimulus(input logic st, input logic [7:0] ln,
                                 input logic vld, input logic [7:0] dat);
        bus.start    = st;
        bus.len      = ln;
        bus.in_valid = vld;
        bus.in_data  = dat;
    endtask

    // Single comparison point: counts and reports on mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Check all handshake outputs plus results of the default instance
    task automatic checkAll(input string tag, input logic rdy, input logic al,
                            input logic rn, input logic [15:0] sm,
                            input logic [7:0] cnt, input logic ovf);
        checkOutput({tag, ".in_ready"}, {31'd0, bus.in_ready}, {31'd0, rdy});
        checkOutput({tag, ".all"},      {31'd0, bus.all},      {31'd0, al});
        checkOutput({tag, ".run"},      {31'd0, bus.run},      {31'd0, rn});
        checkOutput({tag, ".sum"},      {16'd0, bus.sum},      {16'd0, sm});
        checkOutput({tag, ".count"},    {24'd0, bus.count},    {24'd0, cnt});
        checkOutput({tag, ".overflow"}, {31'd0, bus.overflow}, {31'd0, ovf});
    endtask

    initial begin
        compareCount = 0;
        failCount    = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
        bus9.start    = 1'b0;
        bus9.len      = 8'd0;
        bus9.in_valid = 1'b0;
        bus9.in_data  = 8'd0;

        // ---- Reset for two cycles, then idle ----
        tick();
        checkAll("rst1", 1'b0, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0);
        tick();
        checkAll("rst2", 1'b0, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkAll("idle", 1'b0, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0);
        end

        // ---- Basic job: len=4, beats 1..4 back-to-back ----
        applyStimulus(1'b1, 8'd4, 1'b0, 8'd0);
        tick();
        checkAll("basic.start", 1'b1, 1'b0, 1'b1, 16'd0, 8'd0, 1'b0);
        for (int b = 1; b <= 4; b++) begin
            applyStimulus(1'b0, 8'd99, 1'b1, 8'(b));
            checkOutput("basic.beat_ready", {31'd0, bus.in_ready}, 32'd1);
            tick();
        end
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
        checkAll("basic.done", 1'b0, 1'b1, 1'b0, 16'd10, 8'd4, 1'b0);
        tick();
        checkAll("basic.idle", 1'b0, 1'b0, 1'b0, 16'd10, 8'd4, 1'b0);

        // ---- Stalled stream: len=3, beats 5,6,7 with 2-cycle gaps ----
        applyStimulus(1'b1, 8'd3, 1'b0, 8'd0);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
        checkAll("stall.start", 1'b1, 1'b0, 1'b1, 16'd0, 8'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'd0, 1'b1, 8'(5 + i));
            tick();
            applyStimulus(1'b0, 8'd0, 1'b0, 8'hAA);
            if (i < 2) begin
                for (int g = 0; g < 2; g++) begin
                    checkAll("stall.gap", 1'b1, 1'b0, 1'b1,
                             16'(5 * (i + 1) + i * (i + 1) / 2), 8'(i + 1), 1'b0);
                    tick();
                end
            end
        end
        checkAll("stall.done", 1'b0, 1'b1, 1'b0, 16'd18, 8'd3, 1'b0);
        tick();
        checkAll("stall.idle", 1'b0, 1'b0, 1'b0, 16'd18, 8'd3, 1'b0);

        // ---- Zero-length job ----
        applyStimulus(1'b1, 8'd0, 1'b0, 8'd0);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
        checkAll("zero.done", 1'b0, 1'b1, 1'b0, 16'd0, 8'd0, 1'b0);
        tick();
        checkAll("zero.idle", 1'b0, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0);

        // ---- Large job: 255 beats of 0xFF ----
        applyStimulus(1'b1, 8'd255, 1'b0, 8'd0);
        tick();
        for (int i = 0; i < 255; i++) begin
            applyStimulus(1'b0, 8'd0, 1'b1, 8'hFF);
            tick();
        end
        // start held in DONE must be ignored
        applyStimulus(1'b1, 8'd7, 1'b1, 8'hFF);
        checkAll("big.done", 1'b0, 1'b1, 1'b0, 16'hFE01, 8'd255, 1'b0);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
        checkAll("big.idle_after_done_start", 1'b0, 1'b0, 1'b0, 16'hFE01, 8'd255, 1'b0);
        tick();
        checkAll("big.still_idle", 1'b0, 1'b0, 1'b0, 16'hFE01, 8'd255, 1'b0);

        // ---- Second job: two beats of 0xFF ----
        applyStimulus(1'b1, 8'd2, 1'b0, 8'd0);
        tick();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 8'd0, 1'b1, 8'hFF);
            tick();
        end
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
        checkAll("two.done", 1'b0, 1'b1, 1'b0, 16'h01FE, 8'd2, 1'b0);
        tick();

        // ---- 9-bit accumulator: three beats of 0xFF carry out ----
        bus9.start = 1'b1;
        bus9.len   = 8'd3;
        tick();
        bus9.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus9.in_valid = 1'b1;
            bus9.in_data  = 8'hFF;
            tick();
            if (i == 1) begin
                checkOutput("acc9.sum_mid", {23'd0, bus9.sum}, 32'h1FE);
                checkOutput("acc9.ovf_mid", {31'd0, bus9.overflow}, 32'd0);
            end
        end
        bus9.in_valid = 1'b0;
        checkOutput("acc9.all", {31'd0, bus9.all}, 32'd1);
        checkOutput("acc9.overflow", {31'd0, bus9.overflow}, 32'd1);
`ifdef BATCH_ACC_SATURATE_EN
        checkOutput("acc9.sum", {23'd0, bus9.sum}, 32'h1FF);
`else
        checkOutput("acc9.sum", {23'd0, bus9.sum}, 32'h0FD);
`endif
        tick();
        checkOutput("acc9.ovf_held", {31'd0, bus9.overflow}, 32'd1);

        // ---- Abort: len=5, two beats, ignored start, then reset ----
        applyStimulus(1'b1, 8'd5, 1'b0, 8'd0);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b1, 8'd3);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b1, 8'd4);
        tick();
        applyStimulus(1'b1, 8'd1, 1'b0, 8'd0);
        tick();
        checkAll("abort.ignored_start", 1'b1, 1'b0, 1'b1, 16'd7, 8'd2, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
        checkAll("abort.reset", 1'b0, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0);
        tick();
        checkAll("abort.no_all", 1'b0, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0);

        // ---- New single-beat job after abort ----
        applyStimulus(1'b1, 8'd1, 1'b0, 8'd0);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b1, 8'd9);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
        checkAll("one.done", 1'b0, 1'b1, 1'b0, 16'd9, 8'd1, 1'b0);
        tick();
        checkAll("one.idle", 1'b0, 1'b0, 1'b0, 16'd9, 8'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
